data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the CPU MEM-stage data port: accepts one load/store request at a time via
//  valid/ready, services it after a fixed programmable latency and returns a one-cycle response.
//  On halt (StopM) it streams the full memory contents out, one word per cycle, then idles permanently.
//  Replaces the zero-latency data RAM so the hazard unit's MEM-stall path can be exercised.
// PARAMETERS
//  DEPTH     512  number of 32-bit words; byte address range 0 .. 4*DEPTH-1
//  LATENCY   2    cycles from request accept to RespValid (legal 1..15)
//  AW        9    word-index width, $clog2(DEPTH)
// PORTS
//  CLK        in   1   clock, all state updates on rising edge
//  RstN       in   1   asynchronous active-low reset
//  ReqValidM  in   1   CPU presents a request this cycle
//  ReqReadyM  out  1   responder can accept a request; handshake completes when ReqValidM & ReqReadyM
//  MemWriteM  in   1   1 = store, 0 = load; sampled at handshake
//  AddrM      in   32  byte address (ALU output); sampled at handshake
//  WDataM     in   32  store data; sampled at handshake
//  RespValid  out  1   one-cycle pulse: request complete (loads and stores)
//  RDataM     out  32  load data, valid only while RespValid; 0 for stores and errors
//  ErrM       out  1   with RespValid: address misaligned (AddrM[1:0]!=0) or word index >= DEPTH
//  StopM      in   1   halt request from the pipeline; level, sampled each cycle
//  DumpValid  out  1   DumpAddr/DumpData valid this cycle
//  DumpAddr   out  32  byte address of dumped word
//  DumpData   out  32  dumped word
//  DumpDone   out  1   high from the cycle after the last dump word until reset
// BEHAVIOUR
//  Reset: state IDLE; ReqReadyM=1; RespValid, ErrM, DumpValid, DumpDone=0; RDataM, DumpAddr, DumpData=0;
//   latency counter=0. Memory array is not cleared by reset (cleared to 0 at time zero only).
//  FSM IDLE -> BUSY on handshake: latch op/addr/data, load counter with LATENCY-1, drop ReqReadyM.
//  BUSY: decrement each cycle; at 0 perform access and go RESP. Store: write only if no error.
//  RESP: RespValid=1 one cycle (registered output, so handshake-to-RespValid = LATENCY cycles);
//   ReqReadyM=1 in RESP, so a back-to-back request is accepted the same cycle (-> BUSY).
//  Only one outstanding request; ReqValidM while ReqReadyM=0 is ignored (CPU must hold it).
//  Load after store to same address returns the stored value (write committed before RESP).
//  StopM in IDLE or RESP (with no new handshake): -> DUMP. StopM in BUSY: finish current request
//   (RESP still pulses), then DUMP. StopM has priority over a simultaneous ReqValidM.
//  DUMP: ReqReadyM=0; index 0..DEPTH-1, one word per cycle, DumpAddr=4*index; after index DEPTH-1
//   -> HALT with DumpDone=1. HALT ignores all inputs until RstN low.
//  Reset asserted mid-request or mid-dump: abort immediately, outputs to reset values, no pending write.
//  Width rules: word index = AddrM[AW+1:2]; range error if AddrM[31:AW+2] != 0.
// STRUCTURE
//  Shared package/header (alongside global_const.v): state encodings IDLE/BUSY/RESP/DUMP/HALT,
//   DEFAULT_DEPTH, DEFAULT_LATENCY.
//  One sub-module: mem_word_array (sync write, async read, DEPTH x 32), instantiated once;
//   FSM, latency counter and dump counter live in data_mem_responder.
// TESTING
//  1 Reset then store 0xDEADBEEF @0x10, LATENCY=2 -> RespValid exactly 2 cycles after handshake, ErrM=0.
//  2 Load @0x10 issued in RESP cycle of store -> accepted same cycle, RDataM=0xDEADBEEF, no bubble.
//  3 Load @0x13 and @0x800 (DEPTH=512) -> RespValid with ErrM=1, RDataM=0; store @0x800 alters nothing.
//  4 StopM raised in BUSY of store 0x5 @0x0 -> RespValid pulses, then DumpData[0]=0x5, 512 DumpValid
//    cycles, DumpAddr ends 0x7FC, DumpDone=1 and stays; ReqReadyM=0 thereafter.
//  5 RstN low 1 cycle into BUSY of store 0x7 @0x20 -> all outputs reset value; later load @0x20 returns 0.
//  6 LATENCY=1 and LATENCY=15 builds -> handshake-to-RespValid of 1 and 15 cycles respectively.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default build parameters and small address-check helpers.
package data_mem_responder_pkg;

  localparam int DEFAULT_DEPTH   = 512;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUSY = 3'd1,
    ST_RESP = 3'd2,
    ST_DUMP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  // Word accesses must be 4-byte aligned.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data port bundle: request/response handshake, halt request
// and the end-of-run memory dump stream.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        stop;
  logic        dump_valid;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  // CPU side
  modport master (
    output req_valid, mem_write, addr, wdata, stop,
    input  req_ready, resp_valid, rdata, err, dump_valid, dump_addr, dump_data, dump_done
  );

  // Memory side
  modport slave (
    input  req_valid, mem_write, addr, wdata, stop,
    output req_ready, resp_valid, rdata, err, dump_valid, dump_addr, dump_data, dump_done
  );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// DEPTH x 32 word storage: one synchronous write port, one asynchronous
// read port. Contents start at zero and are never touched by reset.
module mem_word_array #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH] = '{default: 32'h0000_0000};

  // Commit a write on the rising edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. Accepts one request at a
// time, completes it after LATENCY cycles with a one-cycle response, and
// on halt streams the whole memory out before idling until reset.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  data_mem_responder_if.slave  bus
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [3:0]    r_cnt;
  logic          r_op_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_stop_pend;
  logic [AW-1:0] r_dump_idx;

  logic          r_req_ready;
  logic          r_resp_valid;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          r_dump_valid;
  logic [31:0]   r_dump_addr;
  logic [31:0]   r_dump_data;
  logic          r_dump_done;

  logic          w_hs;
  logic          w_access;
  logic          w_err;
  logic          w_we;
  logic [AW-1:0] w_addr_idx;
  logic [AW-1:0] w_raddr;
  logic [31:0]   w_rword;

  logic          w_req_ready_nxt;
  logic          w_resp_valid_nxt;
  logic [31:0]   w_rdata_nxt;
  logic          w_err_nxt;
  logic          w_dump_valid_nxt;
  logic [31:0]   w_dump_addr_nxt;
  logic [31:0]   w_dump_data_nxt;
  logic          w_dump_done_nxt;

  // A halt request on the same cycle wins over a new request.
  assign w_hs       = bus.req_valid & r_req_ready & ~bus.stop;
  assign w_access   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_addr_idx = r_addr[AW+1:2];
  assign w_err      = addr_misaligned(r_addr)
                    | (r_addr[31:AW+2] != '0)
                    | ({{(32-AW){1'b0}}, w_addr_idx} >= 32'(DEPTH));
  assign w_we       = w_access & r_op_write & ~w_err;
  assign w_raddr    = (r_state == ST_DUMP) ? r_dump_idx : w_addr_idx;

  mem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_addr_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rword)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a halt seen during BUSY is deferred until after RESP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = bus.stop ? ST_DUMP : (w_hs ? ST_BUSY : ST_IDLE);
      ST_BUSY: w_state_nxt = (r_cnt == 4'd0) ? ST_RESP : ST_BUSY;
      ST_RESP: w_state_nxt = (bus.stop | r_stop_pend) ? ST_DUMP : (w_hs ? ST_BUSY : ST_IDLE);
      ST_DUMP: w_state_nxt = (r_dump_idx == AW'(DEPTH - 1)) ? ST_HALT : ST_DUMP;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, latency countdown, pending halt and dump index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= 4'd0;
      r_op_write  <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_stop_pend <= 1'b0;
      r_dump_idx  <= '0;
    end else begin
      if (w_hs) begin
        r_cnt      <= 4'(LATENCY - 1);
        r_op_write <= bus.mem_write;
        r_addr     <= bus.addr;
        r_wdata    <= bus.wdata;
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if ((r_state == ST_BUSY) && bus.stop) begin
        r_stop_pend <= 1'b1;
      end else begin
        r_stop_pend <= r_stop_pend;
      end
      if (r_state == ST_DUMP) begin
        r_dump_idx <= r_dump_idx + AW'(1);
      end else begin
        r_dump_idx <= r_dump_idx;
      end
    end
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == ST_IDLE)
                     | ((w_state_nxt == ST_RESP) & ~(r_stop_pend | bus.stop));
    w_resp_valid_nxt = w_access;
    w_err_nxt        = w_access & w_err;
    w_rdata_nxt      = (w_access & ~r_op_write & ~w_err) ? w_rword : 32'h0000_0000;
    w_dump_valid_nxt = (r_state == ST_DUMP);
    w_dump_addr_nxt  = (r_state == ST_DUMP) ? {{(30-AW){1'b0}}, r_dump_idx, 2'b00} : 32'h0000_0000;
    w_dump_data_nxt  = (r_state == ST_DUMP) ? w_rword : 32'h0000_0000;
    w_dump_done_nxt  = (r_state == ST_HALT);
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0000_0000;
      r_err        <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= 32'h0000_0000;
      r_dump_data  <= 32'h0000_0000;
      r_dump_done  <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_err        <= w_err_nxt;
      r_dump_valid <= w_dump_valid_nxt;
      r_dump_addr  <= w_dump_addr_nxt;
      r_dump_data  <= w_dump_data_nxt;
      r_dump_done  <= w_dump_done_nxt;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.rdata      = r_rdata;
  assign bus.err        = r_err;
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_done  = r_dump_done;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard-checked request
// responses, halt/dump stream, reset abort and latency variants.
module tb_data_mem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if bus();
  data_mem_responder_if aux1();
  data_mem_responder_if aux15();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  data_mem_responder #(.DEPTH(16), .LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(aux1));
  data_mem_responder #(.DEPTH(16), .LATENCY(15)) u_lat15 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(aux15));

  logic        aux_valid = 1'b0;
  logic        aux_write = 1'b0;
  logic [31:0] aux_addr  = 32'h0;
  logic [31:0] aux_wdata = 32'h0;
  assign aux1.req_valid  = aux_valid;
  assign aux1.mem_write  = aux_write;
  assign aux1.addr       = aux_addr;
  assign aux1.wdata      = aux_wdata;
  assign aux1.stop       = 1'b0;
  assign aux15.req_valid = aux_valid;
  assign aux15.mem_write = aux_write;
  assign aux15.addr      = aux_addr;
  assign aux15.wdata     = aux_wdata;
  assign aux15.stop      = 1'b0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] hs_cyc;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  logic [31:0] exp_mem [DEPTH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_n = name_q.pop_front();
        check({mon_n, "_err"}, 32'(bus.err), 32'(mon_e.err));
        check({mon_n, "_rdata"}, bus.rdata, mon_e.rdata);
        check({mon_n, "_lat"}, 32'(cyc) - mon_e.hs_cyc, 32'(LAT));
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input string nm,
                       output int hs, output logic rv_at_hs);
    exp_t e;
    hs = -1;
    rv_at_hs = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    for (int k = 0; k < 40 && hs < 0; k++) begin
      if (bus.req_ready) begin
        hs = cyc + 1;
        rv_at_hs = bus.resp_valid;
        e.err = e_err;
        e.rdata = e_rd;
        e.hs_cyc = 32'(hs);
        sb_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (hs < 0) check({nm, "_hs_timeout"}, 32'd1, 32'd0);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      check({nm, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      name_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({p, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({p, "_err"}, 32'(bus.err), 32'd0);
    check({p, "_rdata"}, bus.rdata, 32'd0);
    check({p, "_dump_valid"}, 32'(bus.dump_valid), 32'd0);
    check({p, "_dump_addr"}, bus.dump_addr, 32'd0);
    check({p, "_dump_data"}, bus.dump_data, 32'd0);
    check({p, "_dump_done"}, 32'(bus.dump_done), 32'd0);
  endtask

  task automatic aux_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] e_rd, input string nm);
    int hs;
    int l1  = -1;
    int l15 = -1;
    @(negedge clk);
    aux_valid = 1'b1;
    aux_write = wr;
    aux_addr  = a;
    aux_wdata = wd;
    check({nm, "_rdy_l1"}, 32'(aux1.req_ready), 32'd1);
    check({nm, "_rdy_l15"}, 32'(aux15.req_ready), 32'd1);
    hs = cyc + 1;
    @(posedge clk);
    #1 aux_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (aux1.resp_valid && l1 < 0) begin
        l1 = cyc - hs;
        check({nm, "_rdata_l1"}, aux1.rdata, e_rd);
      end
      if (aux15.resp_valid && l15 < 0) begin
        l15 = cyc - hs;
        check({nm, "_rdata_l15"}, aux15.rdata, e_rd);
      end
    end
    check({nm, "_lat_l1"}, 32'(l1), 32'd1);
    check({nm, "_lat_l15"}, 32'(l15), 32'd15);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int   hs0, hs1, wt;
    logic rv;
    bus.req_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.stop      = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    exp_mem[0] = 32'h0000_0005;
    exp_mem[4] = 32'hDEAD_BEEF;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Store then back-to-back load in the RESP cycle.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, "st10", hs0, rv);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "ld10", hs1, rv);
    check("ld10_no_bubble", 32'(rv), 32'd1);
    check("ld10_hs_gap", 32'(hs1 - hs0), 32'(LAT + 1));
    drain("t12");

    // Error cases; erroring stores must leave memory untouched.
    issue(1'b0, 32'h13, 32'h0, 1'b1, 32'h0, "ld13", hs0, rv);
    issue(1'b0, 32'h800, 32'h0, 1'b1, 32'h0, "ld800", hs0, rv);
    issue(1'b1, 32'h800, 32'h1234_5678, 1'b1, 32'h0, "st800", hs0, rv);
    issue(1'b1, 32'h8000_0010, 32'h1111_1111, 1'b1, 32'h0, "st_hi", hs0, rv);
    issue(1'b1, 32'h12, 32'hAAAA_AAAA, 1'b1, 32'h0, "st12", hs0, rv);
    issue(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "ld0", hs0, rv);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "ld10b", hs0, rv);
    drain("t3");

    // Reset one cycle into BUSY of a store: nothing may be written.
    issue(1'b1, 32'h20, 32'h7, 1'b0, 32'h0, "st20", hs0, rv);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    name_q.delete();
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 1'b0, 32'h0, "ld20", hs0, rv);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "ld10c", hs0, rv);
    drain("t5");

    // Halt raised while a store is in flight, then full dump.
    issue(1'b1, 32'h0, 32'h5, 1'b0, 32'h0, "st0", hs0, rv);
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wt = 0;
    while (!bus.dump_valid && wt < 30) begin
      @(negedge clk);
      wt++;
    end
    check("dump_start", 32'(bus.dump_valid), 32'd1);
    check("st0_responded", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("dump_valid", 32'(bus.dump_valid), 32'd1);
      check("dump_addr", bus.dump_addr, 32'(4 * i));
      check("dump_data", bus.dump_data, exp_mem[i]);
      @(negedge clk);
    end
    check("after_dump_valid", 32'(bus.dump_valid), 32'd0);
    check("after_dump_done", 32'(bus.dump_done), 32'd1);
    bus.req_valid = 1'b1;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h10;
    repeat (5) @(negedge clk);
    check("halt_ready", 32'(bus.req_ready), 32'd0);
    check("halt_done", 32'(bus.dump_done), 32'd1);
    check("halt_dump_valid", 32'(bus.dump_valid), 32'd0);
    bus.req_valid = 1'b0;

    // Reset leaves HALT.
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_halt");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency 1 and 15 builds.
    aux_txn(1'b1, 32'h8, 32'hCAFE_0001, 32'h0, "aux_st");
    aux_txn(1'b0, 32'h8, 32'h0, 32'hCAFE_0001, "aux_ld");

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
